// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: arbitrates I/D cache misses onto one memory port,
// streams line refills and single-word stores. Optional macro: REFILL_CRITICAL_WORD_FIRST_EN.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          i_ic_req,
  input  logic [ADDR_W-1:0]             i_ic_addr,
  input  logic                          i_dc_req,
  input  logic                          i_dc_we,
  input  logic [ADDR_W-1:0]             i_dc_addr,
  input  logic [DATA_W-1:0]             i_dc_wdata,
  output logic                          o_mem_rd,
  output logic                          o_mem_wr,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  input  logic                          i_mem_ready,
  output logic                          o_ic_fill_valid,
  output logic                          o_dc_fill_valid,
  output logic [DATA_W-1:0]             o_fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] o_fill_idx,
  output logic                          o_ic_done,
  output logic                          o_dc_done,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned TAG_W = ADDR_W - OFF_W;

  typedef enum logic [2:0] {IDLE, IC_FILL, DC_FILL, DC_WRITE, TURN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nx;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]   ic_start, dc_start;

  logic               mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d;
  logic               ic_fill_valid_d, dc_fill_valid_d;
  logic [DATA_W-1:0]  fill_data_d;
  logic [IDX_W-1:0]   fill_idx_d;
  logic               ic_done_d, dc_done_d, busy_d;

  // Byte offset bits of the latched address never reach the word-aligned bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[1:0];

  // Word address of a given index within the line identified by tag.
  function automatic logic [ADDR_W-1:0] line_word(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, 2'b00};
  endfunction

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign ic_start = i_ic_addr[OFF_W-1:2];
  assign dc_start = i_dc_addr[OFF_W-1:2];
`else
  assign ic_start = '0;
  assign dc_start = '0;
`endif

  assign idx_nx = idx_q + IDX_W'(1);

  // Next state and next registered outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    idx_d           = idx_q;
    beat_d          = beat_q;
    mem_rd_d        = 1'b0;
    mem_wr_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    ic_fill_valid_d = 1'b0;
    dc_fill_valid_d = 1'b0;
    fill_data_d     = o_fill_data;
    fill_idx_d      = o_fill_idx;
    ic_done_d       = 1'b0;
    dc_done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_dc_req) begin
          addr_d  = i_dc_addr;
          wdata_d = i_dc_wdata;
          beat_d  = '0;
          if (i_dc_we) begin
            state_d     = DC_WRITE;
            mem_wr_d    = 1'b1;
            mem_addr_d  = {i_dc_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = i_dc_wdata;
          end else begin
            state_d    = DC_FILL;
            idx_d      = dc_start;
            mem_rd_d   = 1'b1;
            mem_addr_d = line_word(i_dc_addr[ADDR_W-1:OFF_W], dc_start);
          end
        end else if (i_ic_req) begin
          state_d    = IC_FILL;
          addr_d     = i_ic_addr;
          idx_d      = ic_start;
          beat_d     = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = line_word(i_ic_addr[ADDR_W-1:OFF_W], ic_start);
        end
      end

      IC_FILL, DC_FILL: begin
        if (i_mem_ready) begin
          ic_fill_valid_d = (state_q == IC_FILL);
          dc_fill_valid_d = (state_q == DC_FILL);
          fill_data_d     = i_mem_rdata;
          fill_idx_d      = idx_q;
          idx_d           = idx_nx;
          beat_d          = beat_q + IDX_W'(1);
          if (beat_q == IDX_W'(LINE_WORDS - 1)) begin
            state_d   = TURN;
            ic_done_d = (state_q == IC_FILL);
            dc_done_d = (state_q == DC_FILL);
            idx_d     = '0;
            beat_d    = '0;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = line_word(addr_q[ADDR_W-1:OFF_W], idx_nx);
          end
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = line_word(addr_q[ADDR_W-1:OFF_W], idx_q);
        end
      end

      DC_WRITE: begin
        if (i_mem_ready) begin
          state_d   = TURN;
          dc_done_d = 1'b1;
        end else begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = {addr_q[ADDR_W-1:2], 2'b00};
          mem_wdata_d = wdata_q;
        end
      end

      TURN: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset abandons any transfer.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      idx_q           <= '0;
      beat_q          <= '0;
      o_mem_rd        <= 1'b0;
      o_mem_wr        <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wdata     <= '0;
      o_ic_fill_valid <= 1'b0;
      o_dc_fill_valid <= 1'b0;
      o_fill_data     <= '0;
      o_fill_idx      <= '0;
      o_ic_done       <= 1'b0;
      o_dc_done       <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      idx_q           <= idx_d;
      beat_q          <= beat_d;
      o_mem_rd        <= mem_rd_d;
      o_mem_wr        <= mem_wr_d;
      o_mem_addr      <= mem_addr_d;
      o_mem_wdata     <= mem_wdata_d;
      o_ic_fill_valid <= ic_fill_valid_d;
      o_dc_fill_valid <= dc_fill_valid_d;
      o_fill_data     <= fill_data_d;
      o_fill_idx      <= fill_idx_d;
      o_ic_done       <= ic_done_d;
      o_dc_done       <= dc_done_d;
      o_busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus randomized
// traffic checked against a line/beat reference model.
module tb_cache_refill_ctrl;

  localparam int LW = 4;
  localparam int IW = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          i_ic_req, i_dc_req, i_dc_we, i_mem_ready;
  logic [31:0]   i_ic_addr, i_dc_addr, i_dc_wdata, i_mem_rdata;
  logic          o_mem_rd, o_mem_wr, o_ic_fill_valid, o_dc_fill_valid;
  logic          o_ic_done, o_dc_done, o_busy;
  logic [31:0]   o_mem_addr, o_mem_wdata, o_fill_data;
  logic [IW-1:0] o_fill_idx;

  int n_cmp = 0;
  int n_bad = 0;

  cache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr),
    .i_dc_req(i_dc_req), .i_dc_we(i_dc_we), .i_dc_addr(i_dc_addr), .i_dc_wdata(i_dc_wdata),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_ic_fill_valid(o_ic_fill_valid), .o_dc_fill_valid(o_dc_fill_valid),
    .o_fill_data(o_fill_data), .o_fill_idx(o_fill_idx),
    .o_ic_done(o_ic_done), .o_dc_done(o_dc_done), .o_busy(o_busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Control outputs packed {rd, wr, ic_valid, dc_valid, ic_done, dc_done, busy}.
  function automatic logic [6:0] ctl();
    return {o_mem_rd, o_mem_wr, o_ic_fill_valid, o_dc_fill_valid, o_ic_done, o_dc_done, o_busy};
  endfunction

  // One line refill; entered and left just after a falling edge with the DUT idle.
  // mode 0: ready always, 1: random ready, 2: two stall cycles before beat 2.
  task automatic run_fill(input bit is_dc, input logic [31:0] addr, input int mode);
    logic [31:0]   base, exp_addr, prev_data;
    logic [IW-1:0] prev_idx;
    logic [6:0]    exp_v;
    int            start, beat, cyc, stalls;
    bit            prev_acc, last, rdy;
    base = addr & ~32'(LW * 4 - 1);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    start = int'(addr[IW+1:2]);
`else
    start = 0;
`endif
    if (is_dc) begin
      i_dc_req = 1'b1; i_dc_we = 1'b0; i_dc_addr = addr; i_dc_wdata = $urandom;
    end else begin
      i_ic_req = 1'b1; i_ic_addr = addr;
    end
    @(posedge Clk);
    beat = 0; cyc = 0; stalls = 0; prev_acc = 1'b0; prev_data = '0; prev_idx = '0;
    forever begin
      @(negedge Clk);
      last  = prev_acc && (beat == LW);
      exp_v = {!last, 1'b0, prev_acc && !is_dc, prev_acc && is_dc, last && !is_dc, last && is_dc, 1'b1};
      n_cmp++;
      if (ctl() !== exp_v) begin
        n_bad++;
        $display("FAIL fill_ctl addr=%h beat=%0d got=%b want=%b", addr, beat, ctl(), exp_v);
      end
      if (prev_acc) begin
        n_cmp++;
        if ({o_fill_data, o_fill_idx} !== {prev_data, prev_idx}) begin
          n_bad++;
          $display("FAIL fill_word addr=%h got=%h/%0d want=%h/%0d",
                   addr, o_fill_data, o_fill_idx, prev_data, prev_idx);
        end
      end
      if (last) break;
      exp_addr = base + 32'(((start + beat) % LW) * 4);
      n_cmp++;
      if (o_mem_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL fill_addr beat=%0d got=%h want=%h", beat, o_mem_addr, exp_addr);
      end
      // Request-side changes after grant must have no effect.
      if (is_dc) begin
        i_dc_addr = $urandom; i_dc_we = 1'($urandom); i_dc_wdata = $urandom;
      end else begin
        i_ic_addr = $urandom;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      else if (beat == 2 && stalls < 2) begin rdy = 1'b0; stalls++; end
      else rdy = 1'b1;
      i_mem_ready = rdy;
      i_mem_rdata = $urandom;
      prev_acc    = rdy;
      if (rdy) begin
        prev_data = i_mem_rdata;
        prev_idx  = IW'((start + beat) % LW);
        beat++;
      end
      cyc++;
      if (cyc > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL fill_budget addr=%h beats=%0d got=timeout want=done", addr, beat);
        break;
      end
    end
    if (is_dc) i_dc_req = 1'b0; else i_ic_req = 1'b0;
    i_mem_ready = 1'($urandom);
    @(negedge Clk);
    n_cmp++;
    if (ctl() !== 7'b0) begin
      n_bad++;
      $display("FAIL fill_idle addr=%h got=%b want=%b", addr, ctl(), 7'b0);
    end
  endtask

  // Single-word store with a given number of not-ready cycles.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input int stall);
    int n;
    i_dc_req = 1'b1; i_dc_we = 1'b1; i_dc_addr = addr; i_dc_wdata = data;
    @(posedge Clk);
    n = 0;
    forever begin
      @(negedge Clk);
      n_cmp++;
      if ({ctl(), o_mem_addr, o_mem_wdata} !== {7'b0100001, addr & ~32'h3, data}) begin
        n_bad++;
        $display("FAIL store_hold cyc=%0d got=%b/%h/%h want=%b/%h/%h", n, ctl(), o_mem_addr,
                 o_mem_wdata, 7'b0100001, addr & ~32'h3, data);
      end
      i_dc_addr = $urandom; i_dc_wdata = $urandom; i_dc_we = 1'($urandom);
      i_mem_ready = (n == stall);
      n++;
      if (n > stall) break;
    end
    @(negedge Clk);
    n_cmp++;
    if (ctl() !== 7'b0000011) begin
      n_bad++;
      $display("FAIL store_done got=%b want=%b", ctl(), 7'b0000011);
    end
    i_dc_req = 1'b0;
    i_mem_ready = 1'($urandom);
    @(negedge Clk);
    n_cmp++;
    if (ctl() !== 7'b0) begin
      n_bad++;
      $display("FAIL store_idle got=%b want=%b", ctl(), 7'b0);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    i_ic_req = 1'b0; i_dc_req = 1'b0; i_dc_we = 1'b0; i_mem_ready = 1'b1;
    i_ic_addr = '0; i_dc_addr = '0; i_dc_wdata = '0; i_mem_rdata = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({ctl(), o_mem_addr, o_mem_wdata, o_fill_data, o_fill_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%b addr=%h wdata=%h fdata=%h idx=%0d want=all zero",
               ctl(), o_mem_addr, o_mem_wdata, o_fill_data, o_fill_idx);
    end
    Rst = 1'b1;
    i_mem_ready = 1'b0;
  endtask

  task automatic test_idle_ready();
    for (int i = 0; i < 4; i++) begin
      i_mem_ready = 1'b1; i_mem_rdata = $urandom;
      @(negedge Clk);
      n_cmp++;
      if (ctl() !== 7'b0) begin
        n_bad++;
        $display("FAIL idle_ready cyc=%0d got=%b want=%b", i, ctl(), 7'b0);
      end
    end
  endtask

  task automatic test_ic_fill_order();
    run_fill(1'b0, 32'h0000_0104, 0);
  endtask

  task automatic test_priority();
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0300;
    run_fill(1'b1, 32'h0000_0200, 0);
    run_fill(1'b0, 32'h0000_0300, 0);
  endtask

  task automatic test_store_stall();
    run_store(32'h0000_0208, 32'hDEAD_BEEF, 3);
  endtask

  task automatic test_fill_stall();
    run_fill(1'b0, 32'h0000_0104, 2);
    run_fill(1'b1, 32'h0000_0A4C, 2);
  endtask

  task automatic test_reset_midfill();
    i_ic_req = 1'b1; i_ic_addr = 32'h0000_0440; i_mem_ready = 1'b1; i_mem_rdata = $urandom;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({o_busy, o_ic_fill_valid, o_fill_idx} !== {1'b1, 1'b1, IW'(1)}) begin
      n_bad++;
      $display("FAIL midfill_pre got=%b%b/%0d want=11/1", o_busy, o_ic_fill_valid, o_fill_idx);
    end
    Rst = 1'b0; i_ic_req = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({ctl(), o_mem_addr, o_mem_wdata, o_fill_data, o_fill_idx} !== '0) begin
      n_bad++;
      $display("FAIL midfill_reset got=%b addr=%h fdata=%h idx=%0d want=all zero",
               ctl(), o_mem_addr, o_fill_data, o_fill_idx);
    end
    Rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl() !== 7'b0) begin
      n_bad++;
      $display("FAIL midfill_nodone got=%b want=%b", ctl(), 7'b0);
    end
    run_fill(1'b0, 32'h0000_0458, 1);
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 2) run_store($urandom, $urandom, $urandom_range(0, 3));
      else           run_fill(kind == 1, $urandom, 1);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ready();
    test_ic_fill_order();
    test_priority();
    test_store_stall();
    test_fill_stall();
    test_reset_midfill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, byte-address width; DATA_W, 32, word width; LINE_WORDS, 4, words per cache line (power of two, >=2).
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Clk  in  1  rising-edge clock.
REQ-004 Rst  in  1  synchronous active-low reset.
REQ-005 i_ic_req  in  1  I-cache miss request, level, held until o_ic_done.
REQ-006 i_ic_addr  in  ADDR_W  I-cache miss byte address.
REQ-007 i_dc_req  in  1  D-cache request, level, held until o_dc_done.
REQ-008 i_dc_we  in  1  1 = single-word store, 0 = line refill.
REQ-009 i_dc_addr  in  ADDR_W  D-cache byte address.
REQ-010 i_dc_wdata  in  DATA_W  store data.
REQ-011 o_mem_rd / o_mem_wr  out  1 each  memory read / write strobe.
REQ-012 o_mem_addr  out  ADDR_W  word-aligned memory address.
REQ-013 o_mem_wdata  out  DATA_W  memory write data.
REQ-014 i_mem_rdata  in  DATA_W  memory read data, valid when i_mem_ready=1.
REQ-015 i_mem_ready  in  1  memory completes current access this cycle.
REQ-016 o_ic_fill_valid / o_dc_fill_valid  out  1 each  refill word valid for I / D cache.
REQ-017 o_fill_data  out  DATA_W; o_fill_idx  out  log2(LINE_WORDS)  word index within line.
REQ-018 o_ic_done / o_dc_done  out  1 each  one-cycle completion pulse.
REQ-019 o_busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, IC_FILL, DC_FILL, DC_WRITE, TURN.
REQ-021 In IDLE, i_dc_req SHALL take priority over i_ic_req; on grant, address/we/wdata SHALL be latched and next state SHALL be DC_WRITE (we=1), DC_FILL (we=0) or IC_FILL.
REQ-022 Line base SHALL be latched address with low log2(LINE_WORDS)+2 bits cleared; o_mem_addr = base + 4*idx.
REQ-023 In *_FILL, o_mem_rd SHALL be 1 with o_mem_addr stable until a cycle with i_mem_ready=1.
REQ-024 On each ready edge in *_FILL, i_mem_rdata SHALL be registered to o_fill_data, current idx to o_fill_idx, and the matching fill_valid SHALL be 1 the following cycle only.
REQ-025 idx SHALL increment modulo LINE_WORDS; a separate beat counter SHALL count 0..LINE_WORDS-1.
REQ-026 On the ready edge of the final beat, matching done SHALL pulse the following cycle together with the last fill_valid, and state SHALL go to TURN.
REQ-027 In DC_WRITE, o_mem_wr SHALL be 1 with latched address (low 2 bits cleared) and data stable until i_mem_ready=1; o_dc_done SHALL pulse the following cycle; state SHALL go to TURN.
REQ-028 TURN SHALL last exactly one cycle, ignore all requests, then go to IDLE.
REQ-029 o_mem_rd and o_mem_wr SHALL never be 1 simultaneously; no strobe in IDLE or TURN.
REQ-030 i_mem_ready in IDLE or TURN SHALL be ignored; request changes after grant SHALL be ignored.

Reset
REQ-031 With Rst=0 at a rising edge: state IDLE, counters 0, all outputs 0, any in-flight transfer abandoned with no done pulse.

Configuration
REQ-032 Macro REFILL_CRITICAL_WORD_FIRST_EN: defined -> fills start at idx = latched address word offset and wrap; undefined -> fills always start at idx 0. Beat count is LINE_WORDS in both.

Verification
REQ-033 Macro off, I-miss 0x0000_0104, ready always 1 -> o_mem_addr 0x100,0x104,0x108,0x10C; fill_idx 0,1,2,3; o_ic_done with idx 3.
REQ-034 Macro on, same stimulus -> o_mem_addr 0x104,0x108,0x10C,0x100; fill_idx 1,2,3,0; done with idx 0.
REQ-035 i_ic_req and i_dc_req (we=0, 0x200) in the same cycle -> D-line 0x200..0x20C serviced, o_dc_done, one TURN cycle, then I-fill granted.
REQ-036 Store 0x0000_0208 / 0xDEADBEEF, ready low 3 cycles -> o_mem_wr held 4 cycles, addr/data stable, o_dc_done one cycle after ready.
REQ-037 Ready low 2 cycles between beats 1 and 2 -> no fill_valid in the stall cycles, o_mem_addr held at beat-2 address.
REQ-038 Rst=0 after 2 of 4 beats -> next cycle all outputs 0, o_busy 0, no done; a new request is served from beat 0.
